// File: rtl/ysyx_23060077_icache.sv
// ysyx_23060077_icache: direct-mapped read-only instruction cache with AXI burst refill
module ysyx_23060077_icache #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_r_valid_i,
  input  logic [ADDR_WIDTH-1:0] ifu_r_addr_i,
  input  logic [7:0]            ifu_r_len_i,
  output logic                  ifu_r_ready_o,
  output logic                  ifu_r_last_o,
  output logic [DATA_WIDTH-1:0] ifu_r_data_o,
  input  logic                  fence_i_i,
  output logic                  icache_ar_valid_o,
  input  logic                  icache_ar_ready_i,
  output logic [ADDR_WIDTH-1:0] icache_ar_addr_o,
  output logic [7:0]            icache_ar_len_o,
  input  logic                  icache_r_valid_i,
  output logic                  icache_r_ready_o,
  input  logic [DATA_WIDTH-1:0] icache_r_data_i,
  input  logic                  icache_r_last_i,
  input  logic [1:0]            icache_r_resp_i,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int OW = WW + 2;
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - OW - IW;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_AR, REFILL_R, RESP} state_e;
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [SETS-1:0]         valid_q;
  logic [TW-1:0]           tag_q [SETS];
  logic [DATA_WIDTH-1:0]   data_q [SETS][LINE_WORDS];
  logic [DATA_WIDTH-1:0]   buf_q [LINE_WORDS];
  logic [WW:0]             beat_cnt_q;
  logic                    err_q, fence_q;
  logic [31:0]             hit_q, miss_q;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           tag;
  logic [WW-1:0]           word;
  logic                    hit, r_fire, done, install, flush, unused;
  assign idx     = addr_q[OW+IW-1:OW];
  assign tag     = addr_q[ADDR_WIDTH-1:OW+IW];
  assign word    = addr_q[OW-1:2];
  assign hit     = valid_q[idx] && tag_q[idx] == tag;
  assign r_fire  = state_q == REFILL_R && icache_r_valid_i;
  assign done    = (state_q == LOOKUP && hit) || state_q == RESP;
  // beat_cnt_q[WW] set means exactly LINE_WORDS beats arrived; overflow beyond that is flagged in err_q
  assign install = state_q == RESP && !err_q && beat_cnt_q[WW];
  // a pending (or coincident) fence is applied when the access completes, overriding a fresh install
  assign flush   = (state_q == IDLE && fence_i_i) || (done && (fence_q || fence_i_i));
  assign unused  = ^{ifu_r_len_i, addr_q[1:0]};
  // next-state and response/AXI outputs, all decoded from state so reset clears them at once
  always_comb begin
    state_d = state_q == IDLE      ? (ifu_r_valid_i ? LOOKUP : IDLE) :
              state_q == LOOKUP    ? (hit ? IDLE : REFILL_AR) :
              state_q == REFILL_AR ? (icache_ar_ready_i ? REFILL_R : REFILL_AR) :
              state_q == REFILL_R  ? (r_fire && icache_r_last_i ? RESP : REFILL_R) : IDLE;
    ifu_r_ready_o     = done;
    ifu_r_last_o      = done;
    ifu_r_data_o      = state_q == RESP ? buf_q[word] : (state_q == LOOKUP && hit) ? data_q[idx][word] : '0;
    icache_ar_valid_o = state_q == REFILL_AR;
    icache_ar_addr_o  = state_q == REFILL_AR ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
    icache_ar_len_o   = 8'(LINE_WORDS - 1);
    icache_r_ready_o  = state_q == REFILL_R;
    hit_cnt_o         = hit_q;
    miss_cnt_o        = miss_q;
  end
  // control state: FSM, request address, valid bits, refill bookkeeping, fence and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      fence_q    <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && ifu_r_valid_i) addr_q <= ifu_r_addr_i;
      if (flush) valid_q <= '0;
      else if (install) valid_q[idx] <= 1'b1;
      if (done) fence_q <= 1'b0;
      else if (state_q != IDLE && fence_i_i) fence_q <= 1'b1;
      if (state_q == LOOKUP) begin
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end else if (r_fire) begin
        beat_cnt_q <= beat_cnt_q[WW] ? beat_cnt_q : beat_cnt_q + 1'b1;
        err_q      <= err_q || icache_r_resp_i != 2'b00 || beat_cnt_q[WW];
      end
      if (state_q == LOOKUP && hit) hit_q <= hit_q + 32'd1;
      if (state_q == LOOKUP && !hit) miss_q <= miss_q + 32'd1;
    end
  end
  // line buffer capture and line install; storage contents need no reset
  always_ff @(posedge clk) begin
    if (r_fire && !beat_cnt_q[WW]) buf_q[beat_cnt_q[WW-1:0]] <= icache_r_data_i;
    if (install) begin
      tag_q[idx] <= tag;
      for (int k = 0; k < LINE_WORDS; k++) data_q[idx][k] <= buf_q[k];
    end
  end
endmodule

// File: tb/tb_ysyx_23060077_icache.sv
// tb_ysyx_23060077_icache: directed plus randomized accesses checked against a set/tag presence model
module tb_ysyx_23060077_icache;
  logic        clk = 1'b0;
  logic        reset;
  logic        ifu_r_valid_i;
  logic [31:0] ifu_r_addr_i;
  logic [7:0]  ifu_r_len_i;
  logic        ifu_r_ready_o, ifu_r_last_o;
  logic [31:0] ifu_r_data_o;
  logic        fence_i_i;
  logic        icache_ar_valid_o, icache_ar_ready_i;
  logic [31:0] icache_ar_addr_o;
  logic [7:0]  icache_ar_len_o;
  logic        icache_r_valid_i, icache_r_ready_o;
  logic [31:0] icache_r_data_i;
  logic        icache_r_last_i;
  logic [1:0]  icache_r_resp_i;
  logic [31:0] hit_cnt_o, miss_cnt_o;
  int          checks = 0, failures = 0;
  bit          m_valid [16];
  logic [23:0] m_tag [16];
  int          m_hits = 0, m_misses = 0;

  ysyx_23060077_icache dut (
    .clk(clk), .reset(reset),
    .ifu_r_valid_i(ifu_r_valid_i), .ifu_r_addr_i(ifu_r_addr_i), .ifu_r_len_i(ifu_r_len_i),
    .ifu_r_ready_o(ifu_r_ready_o), .ifu_r_last_o(ifu_r_last_o), .ifu_r_data_o(ifu_r_data_o),
    .fence_i_i(fence_i_i),
    .icache_ar_valid_o(icache_ar_valid_o), .icache_ar_ready_i(icache_ar_ready_i),
    .icache_ar_addr_o(icache_ar_addr_o), .icache_ar_len_o(icache_ar_len_o),
    .icache_r_valid_i(icache_r_valid_i), .icache_r_ready_o(icache_r_ready_o),
    .icache_r_data_i(icache_r_data_i), .icache_r_last_i(icache_r_last_i), .icache_r_resp_i(icache_r_resp_i),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = {30'd0, a[3:2]} + 32'd1;
    return a[31:4] == 28'h2000000 ? 32'h11 * w : {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // mode: 0 clean refill, 1 error resp on beat 1, 2 last on 3rd beat, 3 last on 5th beat, 4 fence during refill
  task automatic access(input logic [31:0] a, input int mode, input int ar_delay, input bit fence_same);
    logic [31:0] line;
    int          idx, nbeats;
    bit          exp_hit;
    line = {a[31:4], 4'h0};
    idx  = int'(a[7:4]);
    @(negedge clk);
    ifu_r_valid_i = 1'b1;
    ifu_r_addr_i  = a;
    ifu_r_len_i   = 8'($urandom);
    fence_i_i     = fence_same;
    if (fence_same) model_flush();
    exp_hit = m_valid[idx] && m_tag[idx] == a[31:8];
    @(negedge clk);
    fence_i_i = 1'b0;
    chk("lookup_ready", {31'd0, ifu_r_ready_o}, {31'd0, exp_hit});
    if (exp_hit) begin
      m_hits++;
      chk("hit_data", ifu_r_data_o, mem(a));
      chk("hit_last", {31'd0, ifu_r_last_o}, 32'd1);
      chk("hit_no_ar", {31'd0, icache_ar_valid_o}, 32'd0);
    end else begin
      m_misses++;
      @(negedge clk);
      chk("ar_len", {24'd0, icache_ar_len_o}, 32'd3);
      for (int c = 0; c <= ar_delay; c++) begin
        chk("ar_valid", {31'd0, icache_ar_valid_o}, 32'd1);
        chk("ar_addr", icache_ar_addr_o, line);
        if (c == ar_delay) icache_ar_ready_i = 1'b1;
        @(negedge clk);
      end
      icache_ar_ready_i = 1'b0;
      chk("ar_dropped", {31'd0, icache_ar_valid_o}, 32'd0);
      nbeats = mode == 2 ? 3 : mode == 3 ? 5 : 4;
      for (int b = 0; b < nbeats; b++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        chk("r_ready", {31'd0, icache_r_ready_o}, 32'd1);
        icache_r_valid_i = 1'b1;
        icache_r_data_i  = b < 4 ? mem(line + 32'(4 * b)) : 32'hDEAD_BEEF;
        icache_r_last_i  = b == nbeats - 1;
        icache_r_resp_i  = (mode == 1 && b == 1) ? 2'd2 : 2'd0;
        fence_i_i        = mode == 4 && b == 1;
        @(negedge clk);
        icache_r_valid_i = 1'b0;
        icache_r_last_i  = 1'b0;
        icache_r_resp_i  = 2'd0;
        fence_i_i        = 1'b0;
      end
      chk("resp_ready", {31'd0, ifu_r_ready_o}, 32'd1);
      chk("resp_last", {31'd0, ifu_r_last_o}, 32'd1);
      chk("resp_data", ifu_r_data_o, mem(a));
      if (mode == 0 || mode == 4) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[31:8];
      end
      if (mode == 4) model_flush();
    end
    @(negedge clk);
    ifu_r_valid_i = 1'b0;
    chk("beat_one_cycle", {31'd0, ifu_r_ready_o}, 32'd0);
    chk("hit_cnt", hit_cnt_o, 32'(m_hits));
    chk("miss_cnt", miss_cnt_o, 32'(m_misses));
  endtask

  initial begin
    logic [31:0] a;
    int          mode;
    reset = 1'b1;
    ifu_r_valid_i = 1'b0; ifu_r_addr_i = '0; ifu_r_len_i = '0; fence_i_i = 1'b0;
    icache_ar_ready_i = 1'b0; icache_r_valid_i = 1'b0; icache_r_data_i = '0;
    icache_r_last_i = 1'b0; icache_r_resp_i = '0;
    model_flush();
    #1;
    chk("rst_ready", {31'd0, ifu_r_ready_o}, 32'd0);
    chk("rst_ar_valid", {31'd0, icache_ar_valid_o}, 32'd0);
    chk("rst_hit_cnt", hit_cnt_o, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    // cold miss then hit on the same line
    access(32'h2000_0000, 0, 0, 1'b0);
    access(32'h2000_0004, 0, 0, 1'b0);
    // fence pulse alone in IDLE, then cold miss on the last word
    @(negedge clk); fence_i_i = 1'b1;
    @(negedge clk); fence_i_i = 1'b0;
    model_flush();
    access(32'h2000_000C, 0, 1, 1'b0);
    // conflict on index 0
    access(32'h2000_0100, 0, 0, 1'b0);
    access(32'h2000_0000, 0, 2, 1'b0);
    // fence coinciding with a request, and fence during refill
    access(32'h2000_0004, 0, 0, 1'b0);
    access(32'h2000_0004, 0, 0, 1'b1);
    access(32'h2000_0010, 4, 0, 1'b0);
    access(32'h2000_0010, 0, 0, 1'b0);
    access(32'h2000_0004, 0, 0, 1'b0);
    // error response, early last, late last: none install
    access(32'h2000_0024, 1, 0, 1'b0);
    access(32'h2000_0024, 0, 0, 1'b0);
    access(32'h2000_0030, 2, 0, 1'b0);
    access(32'h2000_0030, 0, 0, 1'b0);
    access(32'h2000_0108, 3, 0, 1'b0);
    access(32'h2000_0108, 0, 0, 1'b0);
    // randomized mix over a small pool of two tags and four sets
    for (int n = 0; n < 80; n++) begin
      a = 32'h2000_0000 | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 3)) << 4);
      mode = $urandom_range(0, 9);
      mode = mode < 5 ? 0 : mode - 5;
      a = a | (32'(mode == 2 ? $urandom_range(0, 2) : $urandom_range(0, 3)) << 2);
      access(a, mode, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
    end
    // stray R beat in IDLE is not accepted
    @(negedge clk);
    icache_r_valid_i = 1'b1;
    #1 chk("stray_r_ready", {31'd0, icache_r_ready_o}, 32'd0);
    @(negedge clk);
    icache_r_valid_i = 1'b0;
    // reset in the middle of a refill
    ifu_r_valid_i = 1'b1; ifu_r_addr_i = 32'h3000_0040;
    @(negedge clk);
    @(negedge clk);
    icache_ar_ready_i = 1'b1;
    @(negedge clk);
    icache_ar_ready_i = 1'b0;
    chk("mid_r_ready", {31'd0, icache_r_ready_o}, 32'd1);
    icache_r_valid_i = 1'b1; icache_r_data_i = 32'h1234_5678;
    @(negedge clk);
    icache_r_valid_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_r_ready", {31'd0, icache_r_ready_o}, 32'd0);
    chk("arst_ifu_ready", {31'd0, ifu_r_ready_o}, 32'd0);
    chk("arst_data", ifu_r_data_o, 32'd0);
    chk("arst_ar_valid", {31'd0, icache_ar_valid_o}, 32'd0);
    chk("arst_ar_addr", icache_ar_addr_o, 32'd0);
    chk("arst_miss_cnt", miss_cnt_o, 32'd0);
    chk("arst_hit_cnt", hit_cnt_o, 32'd0);
    ifu_r_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_flush();
    m_hits = 0;
    m_misses = 0;
    access(32'h2000_0000, 0, 5, 1'b0);
    access(32'h2000_0008, 0, 0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
